// File: rtl/i2c_slave_8bit_if.sv
// i2c_slave_8bit_if: bus pins and register-port bundle for the I2C responder.
// Ports: none. The slave modport is the responder's view, master is the host/bench view.
interface i2c_slave_8bit_if;
    logic       i_scl;
    logic       i_sda;
    logic       o_sda_oe;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_we;
    logic       o_reg_re;
    logic [7:0] i_reg_rdata;
    logic       o_busy;

    modport slave (
        input  i_scl, i_sda, i_reg_rdata,
        output o_sda_oe, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy
    );

    modport master (
        output i_scl, i_sda, i_reg_rdata,
        input  o_sda_oe, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy
    );
endinterface

// File: rtl/i2c_slave_8bit.sv
// i2c_slave_8bit: I2C register-port responder (7-bit address, 8-bit pointer).
// Ports: i_clk, i_rst (async high), bus (slave modport: scl/sda in, sda_oe out,
// register addr/wdata/we/re out, rdata in, busy out).
// Macro I2C_SLAVE_AUTOINC_EN: pointer increments after each written byte and
// each master-ACKed read byte; undefined, the pointer is fixed per transaction.
module i2c_slave_8bit #(
    parameter logic [6:0] SLAVE_ADDR = 7'h21
) (
    input  logic            i_clk,
    input  logic            i_rst,
    i2c_slave_8bit_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;
    logic       busy_q;

    logic       scl, sda, scl_rise, scl_fall, start, stop;
    logic [7:0] rx_byte, addr_inc;

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_hist_q;
    assign scl_fall = ~scl & scl_hist_q;
    // Bus conditions only count while SCL is stably high.
    assign start    = scl & scl_hist_q & ~sda & sda_hist_q;
    assign stop     = scl & scl_hist_q & sda & ~sda_hist_q;
    assign rx_byte  = {rx_q[6:0], sda};

`ifdef I2C_SLAVE_AUTOINC_EN
    assign addr_inc = addr_q + 8'd1;
`else
    assign addr_inc = addr_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        oe_d    = oe_q;
        rw_d    = rw_q;
        if (start) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (scl_fall) oe_d = 1'b0;
                end
                ADDR, REG, WR_DATA: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        rx_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    state_d = ADDR_ACK;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == REG) begin
                                addr_d  = rx_byte;
                                state_d = REG_ACK;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                                state_d = WR_ACK;
                            end
                        end
                    end
                end
                // ACK is asserted on the fall after bit 8; the following
                // state releases or overwrites it on the fall after bit 9.
                ADDR_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d = 3'd0;
                        if (rw_q) begin
                            re_d    = 1'b1;
                            state_d = RD_LOAD;
                        end else begin
                            state_d = REG;
                        end
                    end
                end
                REG_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d   = 3'd0;
                        state_d = WR_DATA;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d   = 3'd0;
                        addr_d  = addr_inc;
                        state_d = WR_DATA;
                    end
                end
                RD_LOAD: begin
                    tx_d    = bus.i_reg_rdata;
                    cnt_d   = 3'd0;
                    state_d = RD_DATA;
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        oe_d = ~tx_q[7];
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = RD_MACK;
                    end
                end
                RD_MACK: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        if (!sda) begin
                            addr_d  = addr_inc;
                            re_d    = 1'b1;
                            state_d = RD_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            cnt_q      <= 3'd0;
            rx_q       <= 8'd0;
            tx_q       <= 8'd0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= {scl_sync_q[0], bus.i_scl};
            sda_sync_q <= {sda_sync_q[0], bus.i_sda};
            scl_hist_q <= scl;
            sda_hist_q <= sda;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Gate with reset so SDA is released combinationally, not at the next edge.
    assign bus.o_sda_oe    = oe_q & ~i_rst;
    assign bus.o_reg_addr  = addr_q;
    assign bus.o_reg_wdata = wdata_q;
    assign bus.o_reg_we    = we_q;
    assign bus.o_reg_re    = re_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_8bit.sv
// tb_i2c_slave_8bit: bus-level bench for i2c_slave_8bit.
// Drives SCL/SDA as an open-drain master and scoreboards strobes and read bytes.
module tb_i2c_slave_8bit;
    localparam int Q = 8;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic [7:0] rdata = 8'h00;
    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;

    logic [15:0] exp_we[$];
    logic [7:0]  exp_re[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  rd_src[$];

    i2c_slave_8bit_if bus();
    assign bus.i_scl       = scl_m;
    assign bus.i_sda       = sda_m & ~bus.o_sda_oe;
    assign bus.i_reg_rdata = rdata;

    i2c_slave_8bit #(.SLAVE_ADDR(7'h21)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.o_sda_oe) oe_cnt++;
        if (bus.o_reg_we) begin
            e = (exp_we.size() != 0) ? {16'h0, exp_we.pop_front()} : 32'hDEAD_BEEF;
            chk("we_strobe", {16'h0, bus.o_reg_addr, bus.o_reg_wdata}, e);
        end
        if (bus.o_reg_re) begin
            e = (exp_re.size() != 0) ? {24'h0, exp_re.pop_front()} : 32'hDEAD_BEEF;
            chk("re_strobe", {24'h0, bus.o_reg_addr}, e);
            rdata = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hEE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic bit_rw(input logic b, output logic s);
        sda_m = b;    wq(Q);
        scl_m = 1'b1; wq(Q);
        s = bus.i_sda; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_rw(d[i], s);
        bit_rw(1'b1, s);
        ack = ~s;
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_rw(1'b1, s);
            d = {d[6:0], s};
        end
        bit_rw(~mack, s);
    endtask

    task automatic rd_check(input string tag, input logic mack);
        logic [7:0] d;
        logic [7:0] e;
        rbyte(mack, d);
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hEE;
        chk(tag, {24'h0, d}, {24'h0, e});
    endtask

    initial begin
        logic ack;
        int oe0;

        wq(4);
        chk("rst_oe", {31'h0, bus.o_sda_oe}, 0);
        chk("rst_addr", {24'h0, bus.o_reg_addr}, 0);
        chk("rst_wdata", {24'h0, bus.o_reg_wdata}, 0);
        chk("rst_busy", {31'h0, bus.o_busy}, 0);
        rst = 1'b0;
        wq(Q);

        // Write 0x10 <- A5, 5A
        i2c_start();
        chk("busy_start", {31'h0, bus.o_busy}, 1);
        wbyte(8'h42, ack); chk("w1_addr_ack", {31'h0, ack}, 1);
        wbyte(8'h10, ack); chk("w1_reg_ack", {31'h0, ack}, 1);
        exp_we.push_back(16'h10A5);
        wbyte(8'hA5, ack); chk("w1_d0_ack", {31'h0, ack}, 1);
        exp_we.push_back({AUTO ? 8'h11 : 8'h10, 8'h5A});
        wbyte(8'h5A, ack); chk("w1_d1_ack", {31'h0, ack}, 1);
        i2c_stop();
        chk("w1_busy", {31'h0, bus.o_busy}, 0);
        chk("w1_addr", {24'h0, bus.o_reg_addr}, {24'h0, AUTO ? 8'h12 : 8'h10});

        // Pointer 0x20, repeated start, read two bytes
        i2c_start();
        wbyte(8'h42, ack); chk("r1_addr_ack", {31'h0, ack}, 1);
        wbyte(8'h20, ack); chk("r1_reg_ack", {31'h0, ack}, 1);
        exp_re.push_back(8'h20); rd_src.push_back(8'h3C); exp_rd.push_back(8'h3C);
        exp_re.push_back(AUTO ? 8'h21 : 8'h20);
        rd_src.push_back(8'h7E); exp_rd.push_back(8'h7E);
        i2c_start();
        wbyte(8'h43, ack); chk("r1_raddr_ack", {31'h0, ack}, 1);
        rd_check("r1_byte0", 1'b1);
        rd_check("r1_byte1", 1'b0);
        i2c_stop();
        chk("r1_busy", {31'h0, bus.o_busy}, 0);
        chk("r1_addr", {24'h0, bus.o_reg_addr}, {24'h0, AUTO ? 8'h21 : 8'h20});

        // Pointer wrap at 0xFF
        i2c_start();
        wbyte(8'h42, ack); chk("wr_addr_ack", {31'h0, ack}, 1);
        wbyte(8'hFF, ack); chk("wr_reg_ack", {31'h0, ack}, 1);
        exp_we.push_back(16'hFF11);
        wbyte(8'h11, ack); chk("wr_d0_ack", {31'h0, ack}, 1);
        exp_we.push_back({AUTO ? 8'h00 : 8'hFF, 8'h22});
        wbyte(8'h22, ack); chk("wr_d1_ack", {31'h0, ack}, 1);
        i2c_stop();

        // STOP after 4 bits of the register byte
        i2c_start();
        wbyte(8'h42, ack); chk("ab_addr_ack", {31'h0, ack}, 1);
        for (int i = 0; i < 4; i++) bit_rw(i[1], ack);
        i2c_stop();
        chk("ab_busy", {31'h0, bus.o_busy}, 0);
        chk("ab_addr", {24'h0, bus.o_reg_addr}, {24'h0, AUTO ? 8'h01 : 8'hFF});

        // Foreign address 0x50
        i2c_start();
        oe0 = oe_cnt;
        wbyte(8'h50, ack);
        chk("na_ack", {31'h0, ack}, 0);
        chk("na_oe", oe_cnt - oe0, 0);
        chk("na_busy", {31'h0, bus.o_busy}, 0);
        i2c_stop();

        // Reset while the slave drives a 0 data bit
        i2c_start();
        wbyte(8'h42, ack); chk("rs_addr_ack", {31'h0, ack}, 1);
        wbyte(8'h30, ack); chk("rs_reg_ack", {31'h0, ack}, 1);
        exp_re.push_back(8'h30); rd_src.push_back(8'h00);
        i2c_start();
        wbyte(8'h43, ack); chk("rs_raddr_ack", {31'h0, ack}, 1);
        chk("rs_oe_drv", {31'h0, bus.o_sda_oe}, 1);
        rst = 1'b1;
        #1;
        chk("rs_oe_rel", {31'h0, bus.o_sda_oe}, 0);
        wq(2);
        chk("rs_addr", {24'h0, bus.o_reg_addr}, 0);
        chk("rs_busy", {31'h0, bus.o_busy}, 0);
        scl_m = 1'b1; sda_m = 1'b1; wq(Q);
        rst = 1'b0; wq(Q);
        i2c_start();
        wbyte(8'h42, ack); chk("rs_after_ack", {31'h0, ack}, 1);
        i2c_stop();

        wq(Q);
        chk("we_left", exp_we.size(), 0);
        chk("re_left", exp_re.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_8bit.md
I2C_SLAVE_8BIT -- requirements
Module: i2c_slave_8bit

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h21, the 7-bit bus address this responder answers to.
REQ-002 SHALL use one clock; reset is asynchronous and active-high. Clock port is i_clk; reset port is i_rst.
REQ-003 i_clk  in  1  system clock, at least 16x SCL frequency.
REQ-004 i_rst  in  1  asynchronous active-high reset.
REQ-005 i_scl  in  1  raw bus SCL, asynchronous.
REQ-006 i_sda  in  1  raw bus SDA, asynchronous.
REQ-007 o_sda_oe  out  1  1 pulls SDA low; 0 releases SDA (open-drain).
REQ-008 o_reg_addr  out  8  register pointer.
REQ-009 o_reg_wdata  out  8  write data.
REQ-010 o_reg_we  out  1  one-cycle write strobe.
REQ-011 o_reg_re  out  1  one-cycle read strobe.
REQ-012 i_reg_rdata  in  8  read data, valid exactly one i_clk after o_reg_re.
REQ-013 o_busy  out  1  high from a detected START until the next STOP or IDLE return.

Function
REQ-014 i_scl and i_sda SHALL each pass a 2-flop synchronizer, then a history register for edge detection. Edge-detect latency is 3 i_clk.
REQ-015 Bus conditions: START = SDA fall while SCL high; STOP = SDA rise while SCL high. Data SHALL be sampled on SCL rise, and o_sda_oe SHALL change only on the i_clk after a detected SCL fall.
REQ-016 State machine states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK.
REQ-017 START in any state SHALL go to ADDR, clear the bit counter, and keep o_reg_addr (repeated start).
REQ-018 STOP in any state SHALL go to IDLE and release SDA.
REQ-019 In ADDR, REG and WR_DATA, bits SHALL shift in MSB first, counted by a 3-bit counter; the 8th SCL rise completes the byte.
REQ-020 ADDR complete, address match, R/W=0: SHALL go to ADDR_ACK, then REG.
REQ-021 ADDR complete, address match, R/W=1: SHALL go to ADDR_ACK and pulse o_reg_re on the ACK SCL rise.
REQ-022 ADDR complete, address mismatch: SHALL go to IDLE with no ACK driven, and ignore the bus until the next START.
REQ-023 In every *_ACK state, o_sda_oe=1 from the SCL fall after bit 8 until the SCL fall after the 9th SCL rise.
REQ-024 REG complete: o_reg_addr SHALL load the byte, then REG_ACK, then WR_DATA.
REQ-025 WR_DATA complete: o_reg_wdata SHALL load the byte and o_reg_we SHALL pulse one cycle on the same i_clk, then WR_ACK, then WR_DATA.
REQ-026 RD_LOAD SHALL capture i_reg_rdata into the transmit shift register one i_clk after o_reg_re.
REQ-027 RD_DATA SHALL drive each bit at SCL fall, MSB first; bit value 0 means o_sda_oe=1, bit value 1 means o_sda_oe=0.
REQ-028 After the 8th bit, RD_DATA SHALL release SDA and go to RD_MACK, sampling master ACK at the 9th SCL rise.
REQ-029 Master ACK (SDA=0) in RD_MACK: SHALL advance the pointer per REQ-033 and pulse o_reg_re, then RD_LOAD.
REQ-030 Master NACK (SDA=1) in RD_MACK: SHALL go to IDLE and wait for STOP.
REQ-031 o_reg_addr SHALL wrap 8'hFF to 8'h00.

Reset
REQ-032 On i_rst, and for as long as it is held: state=IDLE; o_sda_oe=0 (asynchronous, immediate); o_reg_addr=0; o_reg_wdata=0; o_reg_we=0; o_reg_re=0; o_busy=0; synchronizers=1. A reset mid-byte SHALL abandon the transfer.

Configuration
REQ-033 Macro I2C_SLAVE_AUTOINC_EN: defined, o_reg_addr SHALL increment after each written byte and each master-ACKed read byte. Undefined, o_reg_addr SHALL stay fixed for the whole transaction.

Verification
REQ-034 Write 0x42(W), reg 0x10, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; we pulses (0x10,0xA5), then (0x11,0x5A) with AUTOINC, (0x10,0x5A) without.
REQ-035 Write 0x42(W), reg 0x20, repeated START, 0x43(R), master ACK, then NACK, rdata=0x3C then 0x7E -> bus reads 0x3C, 0x7E; re pulses at addr 0x20, 0x21.
REQ-036 Address 0x50 -> o_sda_oe stays 0 through the 9th clock; no strobes; o_busy falls.
REQ-037 Reg 0xFF, write 2 bytes with AUTOINC -> strobes at 0xFF, then 0x00.
REQ-038 Assert i_rst while driving a read 0 bit -> o_sda_oe=0 in the same cycle; next START, 0x42(W) ACKed normally.
REQ-039 STOP after the 4th bit of the register byte -> IDLE; o_reg_addr unchanged; no we pulse.
